lcd_cmd_sequencer: RTL and testbench

- Drives an HD44780-compatible character LCD in 8-bit mode.
- After reset it waits out the power-up time, then plays a fixed 4-command init sequence.
- It then accepts RS/data bytes from a valid/ready client and produces each LCD bus cycle: setup, enable pulse, then the command execution wait.
- All timing is counted in clock_in cycles.

---
 rtl/lcd_pkg.sv | 45 ++++
 rtl/lcd_delay_timer.sv | 24 ++
 rtl/lcd_cmd_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_lcd_cmd_sequencer.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 8-bit command sequencer.
package lcd_pkg;

  localparam int unsigned TMR_W    = 32;
  localparam int unsigned LCD_COLS = 16;

  typedef enum logic [2:0] {
    PWRUP,
    INIT_LOAD,
    SETUP,
    PULSE,
    WAIT,
    IDLE
  } state_t;

  localparam logic [7:0] INIT_BYTE0 = 8'h38;
  localparam logic [7:0] INIT_BYTE1 = 8'h0C;
  localparam logic [7:0] INIT_BYTE2 = 8'h01;
  localparam logic [7:0] INIT_BYTE3 = 8'h06;

  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CMD_HOME  = 8'h02;
  localparam logic [7:0] CMD_LINE0 = 8'h80;
  localparam logic [7:0] CMD_LINE1 = 8'hC0;

  function automatic logic [7:0] init_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    return INIT_BYTE0;
      2'd1:    return INIT_BYTE1;
      2'd2:    return INIT_BYTE2;
      default: return INIT_BYTE3;
    endcase
  endfunction

  // A zero-length interval still occupies one cycle.
  function automatic logic [TMR_W-1:0] cyc_clamp(input int unsigned v);
    return (v == 0) ? TMR_W'(1) : TMR_W'(v);
  endfunction

  // Clear (0x01) and Home (0x02/0x03) need the long execution wait.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] d);
    return !rs && (d[7:2] == 6'd0) && (d[1:0] != 2'd0);
  endfunction

endpackage

// File: rtl/lcd_delay_timer.sv
// Loadable 32-bit down-counter; o_done_c marks the last cycle of a loaded interval.
module lcd_delay_timer
  import lcd_pkg::*;
#(
  parameter logic [TMR_W-1:0] RESET_VAL = TMR_W'(1)
) (
  input  logic             clock_in,
  input  logic             reset,
  input  logic             i_load,
  input  logic [TMR_W-1:0] i_value,
  output logic             o_done_c
);

  logic [TMR_W-1:0] r_count;

  always_ff @(posedge clock_in) begin
    if (reset)                r_count <= RESET_VAL;
    else if (i_load)          r_count <= i_value;
    else if (r_count != '0)   r_count <= r_count - TMR_W'(1);
  end

  assign o_done_c = (r_count <= TMR_W'(1));

endmodule

// File: rtl/lcd_cmd_sequencer.sv
// HD44780 8-bit write sequencer: power-up wait, fixed init, then client byte transfers.
// Define LCD_AUTOWRAP_EN to track the 16x2 cursor and insert line-wrap commands.
module lcd_cmd_sequencer
  import lcd_pkg::*;
#(
  parameter int unsigned POWERUP_CYC    = 750000,
  parameter int unsigned SETUP_CYC      = 4,
  parameter int unsigned EN_HIGH_CYC    = 25,
  parameter int unsigned CMD_WAIT_CYC   = 2500,
  parameter int unsigned CLEAR_WAIT_CYC = 82000
) (
  input  logic       clock_in,
  input  logic       reset,
  input  logic       i_wr_valid,
  output logic       o_wr_ready,
  input  logic       i_wr_rs,
  input  logic [7:0] i_wr_data,
  output logic [7:0] o_lcd_data,
  output logic       o_lcd_rs,
  output logic       o_lcd_rw,
  output logic       o_lcd_en,
  output logic       o_init_done,
  output logic       o_busy
);

  localparam logic [TMR_W-1:0] P_POWERUP = cyc_clamp(POWERUP_CYC);
  localparam logic [TMR_W-1:0] P_SETUP   = cyc_clamp(SETUP_CYC);
  localparam logic [TMR_W-1:0] P_EN      = cyc_clamp(EN_HIGH_CYC);
  localparam logic [TMR_W-1:0] P_CMD     = cyc_clamp(CMD_WAIT_CYC);
  localparam logic [TMR_W-1:0] P_CLEAR   = cyc_clamp(CLEAR_WAIT_CYC);
  // INIT_LOAD already presents the byte, so it counts as the first setup cycle.
  localparam logic [TMR_W-1:0] P_SETUP_INIT = (P_SETUP > TMR_W'(1)) ? P_SETUP - TMR_W'(1) : TMR_W'(1);

  state_t           r_state, w_state_nxt;
  logic [7:0]       r_lcd_data, w_data_nxt;
  logic             r_lcd_rs, w_rs_nxt;
  logic             r_lcd_en, r_wr_ready, r_busy;
  logic             r_init_done, w_init_done_nxt;
  logic [1:0]       r_init_idx, w_init_idx_nxt;
  logic             w_tmr_load, w_tmr_done;
  logic [TMR_W-1:0] w_tmr_value;

`ifdef LCD_AUTOWRAP_EN
  localparam int unsigned COL_W = $clog2(LCD_COLS);
  logic [COL_W:0] r_pos, w_pos_nxt;
  logic           w_wrap;

  always_ff @(posedge clock_in) begin
    if (reset) r_pos <= '0;
    else       r_pos <= w_pos_nxt;
  end
`endif

  lcd_delay_timer #(
    .RESET_VAL(P_POWERUP)
  ) u_timer (
    .clock_in(clock_in),
    .reset   (reset),
    .i_load  (w_tmr_load),
    .i_value (w_tmr_value),
    .o_done_c(w_tmr_done)
  );

  // State and registered outputs.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      r_state     <= PWRUP;
      r_lcd_data  <= 8'h00;
      r_lcd_rs    <= 1'b0;
      r_lcd_en    <= 1'b0;
      r_wr_ready  <= 1'b0;
      r_init_done <= 1'b0;
      r_busy      <= 1'b1;
      r_init_idx  <= 2'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_lcd_data  <= w_data_nxt;
      r_lcd_rs    <= w_rs_nxt;
      r_lcd_en    <= (w_state_nxt == PULSE);
      r_wr_ready  <= (w_state_nxt == IDLE);
      r_init_done <= w_init_done_nxt;
      r_busy      <= (w_state_nxt != IDLE);
      r_init_idx  <= w_init_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_data_nxt      = r_lcd_data;
    w_rs_nxt        = r_lcd_rs;
    w_init_done_nxt = r_init_done;
    w_init_idx_nxt  = r_init_idx;
    w_tmr_load      = 1'b0;
    w_tmr_value     = P_CMD;
`ifdef LCD_AUTOWRAP_EN
    w_pos_nxt = r_pos;
    // A character that just rolled the column to 0 has filled its row.
    w_wrap    = r_lcd_rs && (r_pos[COL_W-1:0] == '0);
`endif
    case (r_state)
      PWRUP: begin
        if (w_tmr_done) begin
          w_state_nxt = INIT_LOAD;
          w_data_nxt  = init_byte(r_init_idx);
          w_rs_nxt    = 1'b0;
        end
      end
      INIT_LOAD: begin
        w_state_nxt = SETUP;
        w_tmr_load  = 1'b1;
        w_tmr_value = P_SETUP_INIT;
      end
      SETUP: begin
        if (w_tmr_done) begin
          w_state_nxt = PULSE;
          w_tmr_load  = 1'b1;
          w_tmr_value = P_EN;
        end
      end
      PULSE: begin
        if (w_tmr_done) begin
          w_state_nxt = WAIT;
          w_tmr_load  = 1'b1;
          w_tmr_value = is_long_cmd(r_lcd_rs, r_lcd_data) ? P_CLEAR : P_CMD;
        end
      end
      WAIT: begin
        if (w_tmr_done) begin
          if (!r_init_done) begin
            if (r_init_idx == 2'd3) begin
              w_init_done_nxt = 1'b1;
              w_state_nxt     = IDLE;
            end else begin
              w_init_idx_nxt = r_init_idx + 2'd1;
              w_state_nxt    = INIT_LOAD;
              w_data_nxt     = init_byte(r_init_idx + 2'd1);
              w_rs_nxt       = 1'b0;
            end
          end
`ifdef LCD_AUTOWRAP_EN
          else if (w_wrap) begin
            w_state_nxt = SETUP;
            w_tmr_load  = 1'b1;
            w_tmr_value = P_SETUP;
            w_data_nxt  = r_pos[COL_W] ? CMD_LINE1 : CMD_LINE0;
            w_rs_nxt    = 1'b0;
          end
`endif
          else begin
            w_state_nxt = IDLE;
          end
        end
      end
      IDLE: begin
        if (i_wr_valid && r_wr_ready) begin
          w_state_nxt = SETUP;
          w_tmr_load  = 1'b1;
          w_tmr_value = P_SETUP;
          w_data_nxt  = i_wr_data;
          w_rs_nxt    = i_wr_rs;
`ifdef LCD_AUTOWRAP_EN
          if (i_wr_rs)                             w_pos_nxt = r_pos + (COL_W + 1)'(1);
          else if (is_long_cmd(1'b0, i_wr_data))   w_pos_nxt = '0;
          else if (i_wr_data[7])                   w_pos_nxt = {i_wr_data[6], i_wr_data[COL_W-1:0]};
`endif
        end
      end
      default: w_state_nxt = PWRUP;
    endcase
  end

  assign o_wr_ready  = r_wr_ready;
  assign o_lcd_data  = r_lcd_data;
  assign o_lcd_rs    = r_lcd_rs;
  assign o_lcd_rw    = 1'b0;
  assign o_lcd_en    = r_lcd_en;
  assign o_init_done = r_init_done;
  assign o_busy      = r_busy;

endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
// Self-checking bench for lcd_cmd_sequencer: bus monitor plus transfer-level reference model.
module tb_lcd_cmd_sequencer;

  localparam int P_PWR = 20;
  localparam int P_SET = 2;
  localparam int P_EN  = 4;
  localparam int P_CMD = 10;
  localparam int P_CLR = 30;

  logic       clock_in = 1'b0;
  logic       reset    = 1'b1;
  logic       wr_valid = 1'b0;
  logic       wr_rs    = 1'b0;
  logic [7:0] wr_data  = 8'h00;
  logic       wr_ready, lcd_rs, lcd_rw, lcd_en, init_done, busy;
  logic [7:0] lcd_data;

  lcd_cmd_sequencer #(
    .POWERUP_CYC   (P_PWR),
    .SETUP_CYC     (P_SET),
    .EN_HIGH_CYC   (P_EN),
    .CMD_WAIT_CYC  (P_CMD),
    .CLEAR_WAIT_CYC(P_CLR)
  ) dut (
    .clock_in   (clock_in),
    .reset      (reset),
    .i_wr_valid (wr_valid),
    .o_wr_ready (wr_ready),
    .i_wr_rs    (wr_rs),
    .i_wr_data  (wr_data),
    .o_lcd_data (lcd_data),
    .o_lcd_rs   (lcd_rs),
    .o_lcd_rw   (lcd_rw),
    .o_lcd_en   (lcd_en),
    .o_init_done(init_done),
    .o_busy     (busy)
  );

  always #5 clock_in = ~clock_in;

  int cyc = 0;
  always @(posedge clock_in) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  int rst_cyc = 0;

  logic [7:0] init_rom [4] = '{8'h38, 8'h0C, 8'h01, 8'h06};

  // Observed enable pulses on the LCD bus.
  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         rise;
    int         fall;
    int         setup;
    int         chg;
    bit         glitch;
  } pulse_t;

  typedef struct {
    logic       rs;
    logic [7:0] data;
  } xfer_t;

  pulse_t pulse_q[$];
  xfer_t  exp_q[$];
  pulse_t cur;
  logic [7:0] pd;
  logic       pr;
  logic       pe = 1'b0;
  int         stable_cnt = 0;
  int         chg_cyc = 0;

  always @(negedge clock_in) begin
    logic changed;
    changed = (lcd_data !== pd) || (lcd_rs !== pr);
    if (lcd_en === 1'b1) begin
      if (pe !== 1'b1) begin
        cur.rs     = lcd_rs;
        cur.data   = lcd_data;
        cur.rise   = cyc;
        cur.setup  = stable_cnt;
        cur.chg    = chg_cyc;
        cur.glitch = changed;
      end else if (changed) begin
        cur.glitch = 1'b1;
      end
    end else begin
      if (pe === 1'b1) begin
        cur.fall = cyc;
        pulse_q.push_back(cur);
      end
      if (changed) begin
        stable_cnt = 1;
        chg_cyc    = cyc;
      end else begin
        stable_cnt++;
      end
    end
    pd = lcd_data;
    pr = lcd_rs;
    pe = lcd_en;
  end

  // Reference model: execution wait and cursor rules applied per transfer.
  int m_row = 0;
  int m_col = 0;

  function automatic int wait_of(input logic rs, input logic [7:0] d);
    return (!rs && d >= 8'h01 && d <= 8'h03) ? P_CLR : P_CMD;
  endfunction

  function automatic int model_xfer(input logic rs, input logic [7:0] d);
    xfer_t x;
    int    lat;
    lat    = P_SET + P_EN + wait_of(rs, d);
    x.rs   = rs;
    x.data = d;
    exp_q.push_back(x);
`ifdef LCD_AUTOWRAP_EN
    if (rs) begin
      m_col++;
      if (m_col == 16) begin
        m_col  = 0;
        m_row  = 1 - m_row;
        x.rs   = 1'b0;
        x.data = (m_row == 1) ? 8'hC0 : 8'h80;
        exp_q.push_back(x);
        lat += P_SET + P_EN + P_CMD;
      end
    end else if (wait_of(rs, d) == P_CLR) begin
      m_row = 0;
      m_col = 0;
    end else if (d[7]) begin
      m_row = int'(d[6]);
      m_col = int'(d[3:0]);
    end
`endif
    return lat;
  endfunction

  task automatic wait_ready(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clock_in);
      if (wr_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Offers one byte, returns cycles from the accept edge until wr_ready is back.
  task automatic send_byte(input logic rs, input logic [7:0] d, output int lat, output bit ok);
    int ca;
    lat = -1;
    wait_ready(4000, ok);
    if (!ok) return;
    ca       = cyc + 1;
    wr_valid = 1'b1;
    wr_rs    = rs;
    wr_data  = d;
    @(negedge clock_in);
    wr_valid = 1'b0;
    wr_rs    = 1'($urandom_range(0, 1));
    wr_data  = 8'($urandom);
    wait_ready(4000, ok);
    lat = cyc - ca;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clock_in);
    checks++; if (lcd_data !== 8'h00) begin failures++; $display("FAIL reset_lcd_data got=%h exp=00", lcd_data); end
    checks++; if (lcd_rs !== 1'b0) begin failures++; $display("FAIL reset_lcd_rs got=%b exp=0", lcd_rs); end
    checks++; if (lcd_rw !== 1'b0) begin failures++; $display("FAIL reset_lcd_rw got=%b exp=0", lcd_rw); end
    checks++; if (lcd_en !== 1'b0) begin failures++; $display("FAIL reset_lcd_en got=%b exp=0", lcd_en); end
    checks++; if (wr_ready !== 1'b0) begin failures++; $display("FAIL reset_wr_ready got=%b exp=0", wr_ready); end
    checks++; if (init_done !== 1'b0) begin failures++; $display("FAIL reset_init_done got=%b exp=0", init_done); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL reset_busy got=%b exp=1", busy); end
    pulse_q.delete();
    exp_q.delete();
    m_row   = 0;
    m_col   = 0;
    rst_cyc = cyc;
    reset   = 1'b0;
  endtask

  task automatic test_init;
    bit ok;
    int exp_lat;
    ok = 1'b0;
    exp_lat = P_PWR;
    for (int i = 0; i < 4; i++) exp_lat += P_SET + P_EN + wait_of(1'b0, init_rom[i]);
    for (int n = 0; n < 1000; n++) begin
      @(negedge clock_in);
      if (init_done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok || (cyc - rst_cyc) !== exp_lat) begin
      failures++; $display("FAIL init_latency got=%0d exp=%0d", cyc - rst_cyc, exp_lat);
    end
    checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL init_wr_ready got=%b exp=1", wr_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL init_busy got=%b exp=0", busy); end
    checks++;
    if (pulse_q.size() !== 4) begin
      failures++; $display("FAIL init_pulse_count got=%0d exp=4", pulse_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        int gap, exp_gap;
        checks++;
        if (pulse_q[i].rs !== 1'b0 || pulse_q[i].data !== init_rom[i]) begin
          failures++; $display("FAIL init_byte%0d got=%b/%h exp=0/%h", i, pulse_q[i].rs, pulse_q[i].data, init_rom[i]);
        end
        checks++;
        if (pulse_q[i].fall - pulse_q[i].rise !== P_EN) begin
          failures++; $display("FAIL init_width%0d got=%0d exp=%0d", i, pulse_q[i].fall - pulse_q[i].rise, P_EN);
        end
        checks++;
        if (pulse_q[i].setup !== P_SET || pulse_q[i].glitch) begin
          failures++; $display("FAIL init_setup%0d got=%0d glitch=%0d exp=%0d", i, pulse_q[i].setup, pulse_q[i].glitch, P_SET);
        end
        gap     = (i == 0) ? pulse_q[i].chg - rst_cyc : pulse_q[i].chg - pulse_q[i-1].fall;
        exp_gap = (i == 0) ? P_PWR : wait_of(1'b0, init_rom[i-1]);
        checks++;
        if (gap !== exp_gap) begin
          failures++; $display("FAIL init_gap%0d got=%0d exp=%0d", i, gap, exp_gap);
        end
      end
    end
  endtask

  task automatic test_char_and_clear;
    int lat;
    bit ok;
    pulse_q.delete();
    exp_q.delete();
    send_byte(1'b1, 8'h41, lat, ok);
    checks++; if (!ok || lat !== model_xfer(1'b1, 8'h41)) begin failures++; $display("FAIL char_latency got=%0d ok=%0d", lat, ok); end
    send_byte(1'b0, 8'h01, lat, ok);
    checks++; if (!ok || lat !== model_xfer(1'b0, 8'h01)) begin failures++; $display("FAIL clear_latency got=%0d ok=%0d", lat, ok); end
    send_byte(1'b1, 8'h01, lat, ok);
    checks++; if (!ok || lat !== model_xfer(1'b1, 8'h01)) begin failures++; $display("FAIL data01_latency got=%0d ok=%0d", lat, ok); end
    checks++;
    if (pulse_q.size() !== exp_q.size()) begin
      failures++; $display("FAIL cmd_pulse_count got=%0d exp=%0d", pulse_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < pulse_q.size(); i++) begin
        checks++;
        if (pulse_q[i].rs !== exp_q[i].rs || pulse_q[i].data !== exp_q[i].data || pulse_q[i].glitch ||
            pulse_q[i].fall - pulse_q[i].rise !== P_EN || pulse_q[i].setup !== P_SET) begin
          failures++;
          $display("FAIL cmd_pulse%0d got=%b/%h w=%0d s=%0d exp=%b/%h w=%0d s=%0d", i, pulse_q[i].rs, pulse_q[i].data,
                   pulse_q[i].fall - pulse_q[i].rise, pulse_q[i].setup, exp_q[i].rs, exp_q[i].data, P_EN, P_SET);
        end
      end
    end
  endtask

  task automatic test_random;
    int lat, exp_lat;
    bit ok;
    logic rs;
    logic [7:0] d;
    pulse_q.delete();
    exp_q.delete();
    for (int i = 0; i < 24; i++) begin
      rs = 1'($urandom_range(0, 1));
      d  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 3)) : 8'($urandom);
      exp_lat = model_xfer(rs, d);
      send_byte(rs, d, lat, ok);
      checks++;
      if (!ok || lat !== exp_lat) begin
        failures++; $display("FAIL rand_latency%0d rs=%b d=%h got=%0d exp=%0d", i, rs, d, lat, exp_lat);
      end
    end
    checks++;
    if (pulse_q.size() !== exp_q.size()) begin
      failures++; $display("FAIL rand_pulse_count got=%0d exp=%0d", pulse_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < pulse_q.size(); i++) begin
        checks++;
        if (pulse_q[i].rs !== exp_q[i].rs || pulse_q[i].data !== exp_q[i].data || pulse_q[i].glitch ||
            pulse_q[i].fall - pulse_q[i].rise !== P_EN) begin
          failures++;
          $display("FAIL rand_pulse%0d got=%b/%h exp=%b/%h", i, pulse_q[i].rs, pulse_q[i].data, exp_q[i].rs, exp_q[i].data);
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    logic       b_rs [3] = '{1'b1, 1'b0, 1'b1};
    logic [7:0] b_d  [3] = '{8'h42, 8'h0E, 8'h43};
    int k;
    bit ok;
    pulse_q.delete();
    exp_q.delete();
    for (int i = 0; i < 3; i++) void'(model_xfer(b_rs[i], b_d[i]));
    k  = 0;
    ok = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clock_in);
      if (wr_ready === 1'b1) begin
        if (k == 3) begin
          wr_valid = 1'b0;
          ok = 1'b1;
          break;
        end
        wr_valid = 1'b1;
        wr_rs    = b_rs[k];
        wr_data  = b_d[k];
        k++;
      end else begin
        // Noise while busy must never be taken.
        wr_valid = 1'($urandom_range(0, 1));
        wr_rs    = 1'($urandom_range(0, 1));
        wr_data  = 8'($urandom);
      end
    end
    wr_valid = 1'b0;
    checks++; if (!ok) begin failures++; $display("FAIL b2b_timeout got=%0d sent exp=3", k); end
    checks++;
    if (pulse_q.size() !== exp_q.size()) begin
      failures++; $display("FAIL b2b_pulse_count got=%0d exp=%0d", pulse_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < pulse_q.size(); i++) begin
        checks++;
        if (pulse_q[i].rs !== exp_q[i].rs || pulse_q[i].data !== exp_q[i].data || pulse_q[i].glitch) begin
          failures++;
          $display("FAIL b2b_pulse%0d got=%b/%h exp=%b/%h", i, pulse_q[i].rs, pulse_q[i].data, exp_q[i].rs, exp_q[i].data);
        end
      end
    end
  endtask

`ifdef LCD_AUTOWRAP_EN
  task automatic test_autowrap;
    int lat, exp_lat;
    bit ok;
    pulse_q.delete();
    exp_q.delete();
    exp_lat = model_xfer(1'b0, 8'h01);
    send_byte(1'b0, 8'h01, lat, ok);
    checks++; if (!ok || lat !== exp_lat) begin failures++; $display("FAIL wrap_clear got=%0d exp=%0d", lat, exp_lat); end
    for (int i = 0; i < 17; i++) begin
      exp_lat = model_xfer(1'b1, 8'(8'h41 + i));
      send_byte(1'b1, 8'(8'h41 + i), lat, ok);
      checks++;
      if (!ok || lat !== exp_lat) begin failures++; $display("FAIL wrap_char%0d got=%0d exp=%0d", i, lat, exp_lat); end
    end
    checks++;
    if (pulse_q.size() !== 19) begin
      failures++; $display("FAIL wrap_pulse_count got=%0d exp=19", pulse_q.size());
    end else begin
      checks++;
      if (pulse_q[17].rs !== 1'b0 || pulse_q[17].data !== 8'hC0) begin
        failures++; $display("FAIL wrap_insert got=%b/%h exp=0/c0", pulse_q[17].rs, pulse_q[17].data);
      end
      checks++;
      if (pulse_q[18].rs !== 1'b1 || pulse_q[18].data !== 8'h51) begin
        failures++; $display("FAIL wrap_char17 got=%b/%h exp=1/51", pulse_q[18].rs, pulse_q[18].data);
      end
    end
  endtask
`endif

  task automatic test_reset_mid_pulse;
    bit ok;
    wait_ready(4000, ok);
    wr_valid = 1'b1;
    wr_rs    = 1'b1;
    wr_data  = 8'h55;
    @(negedge clock_in);
    wr_valid = 1'b0;
    ok = 1'b0;
    for (int n = 0; n < 100; n++) begin
      if (lcd_en === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clock_in);
    end
    checks++; if (!ok) begin failures++; $display("FAIL midrst_no_pulse got=0 exp=1"); end
    reset = 1'b1;
    @(negedge clock_in);
    checks++; if (lcd_en !== 1'b0) begin failures++; $display("FAIL midrst_lcd_en got=%b exp=0", lcd_en); end
    checks++; if (init_done !== 1'b0) begin failures++; $display("FAIL midrst_init_done got=%b exp=0", init_done); end
    checks++; if (wr_ready !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL midrst_ready_busy got=%b/%b exp=0/1", wr_ready, busy); end
    checks++; if (lcd_data !== 8'h00) begin failures++; $display("FAIL midrst_lcd_data got=%h exp=00", lcd_data); end
    @(negedge clock_in);
    pulse_q.delete();
    exp_q.delete();
    m_row   = 0;
    m_col   = 0;
    rst_cyc = cyc;
    reset   = 1'b0;
  endtask

  initial begin
    test_reset;
    test_init;
    test_char_and_clear;
    test_random;
    test_back_to_back;
`ifdef LCD_AUTOWRAP_EN
    test_autowrap;
`endif
    test_reset_mid_pulse;
    test_init;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
